vga_layer_arb: RTL

Per-pixel layer arbiter and frame-synchronous configuration controller for the VGA pixel stream. Sits between the background draw stage and the VGA output register. It takes one timing/background stream on a vga_if plus N sprite layers (cat, dog, projectile, HUD…) and emits one composited vga_if stream. A req/ack handshake lets game logic change the enabled-layer set, with changes committed only at the start of vertical blanking, so a frame never tears mid-scan.

---
 rtl/vga_layer_arb_pkg.sv | 14 +
 rtl/vga_layer_arb_if.sv | 14 +
 rtl/vga_layer_arb_prio.sv | 22 ++
 rtl/vga_layer_arb.sv | 124 ++++++++++++
 4 files changed

// File: rtl/vga_layer_arb_pkg.sv
// rtl/vga_layer_arb_pkg.sv - shared widths, config FSM states and helpers for the layer arbiter
package vga_arb_pkg;
  localparam int RGB_W        = 12;
  localparam int CNT_W        = 11;
  localparam int N_LAYERS_MAX = 8;
  localparam int IDX_W        = $clog2(N_LAYERS_MAX);

  typedef enum logic [1:0] {IDLE, PENDING, COMMIT, WAIT_DROP} cfg_state_t;

  // True when two or more bits are set: clearing the lowest set bit leaves something behind.
  function automatic logic multi_hot(input logic [N_LAYERS_MAX-1:0] v);
    return (v & (v - 1'b1)) != '0;
  endfunction
endpackage

// File: rtl/vga_layer_arb_if.sv
// rtl/vga_layer_arb_if.sv - VGA timing + rgb bundle with driver (out) and receiver (in) views
interface vga_if;
  import vga_arb_pkg::*;
  logic [CNT_W-1:0] vcount;
  logic [CNT_W-1:0] hcount;
  logic             vsync;
  logic             hsync;
  logic             vblnk;
  logic             hblnk;
  logic [RGB_W-1:0] rgb;

  modport out (output vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
  modport in  (input  vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
endinterface

// File: rtl/vga_layer_arb_prio.sv
// rtl/vga_layer_arb_prio.sv - layer_prio_enc: lowest-set-bit priority encoder (index 0 wins)
module layer_prio_enc
  import vga_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     req,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);
  // Scan downward so the lowest set bit is the last one written.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end
endmodule

// File: rtl/vga_layer_arb.sv
// rtl/vga_layer_arb.sv - two-stage per-pixel layer compositor with vblank-committed enable mask
// Optional collision tracking is built when LAYER_ARB_COLLISION_EN is defined.
module vga_layer_arb
  import vga_arb_pkg::*;
#(
  parameter int               N_LAYERS  = 4,
  parameter logic [RGB_W-1:0] BLANK_RGB = 12'h000
) (
  input  logic                            clk,
  input  logic                            rst,
  vga_if.in                               vga_in,
  vga_if.out                              vga_out,
  input  logic [N_LAYERS-1:0][RGB_W-1:0]  layer_rgb,
  input  logic [N_LAYERS-1:0]             layer_valid,
  input  logic                            cfg_req,
  input  logic [N_LAYERS-1:0]             cfg_mask,
  output logic                            cfg_ack,
  output logic [N_LAYERS-1:0]             layer_en,
  output logic                            collision,
  output logic [N_LAYERS-1:0]             collision_mask
);
  cfg_state_t           state;
  logic [N_LAYERS-1:0]  pend_mask;
  logic                 vblnk_q;
  logic                 vblank_rise;
  logic [N_LAYERS-1:0]  vis;
  logic                 win_hit;
  logic [IDX_W-1:0]     win_idx;
  logic [RGB_W-1:0]     win_rgb;

  logic [CNT_W-1:0]     s1_hcount, s1_vcount;
  logic                 s1_hsync, s1_vsync, s1_hblnk, s1_vblnk, s1_blank;
  logic [RGB_W-1:0]     s1_rgb;

  assign vblank_rise = vga_in.vblnk & ~vblnk_q;
  assign vis         = layer_en & layer_valid;

  layer_prio_enc #(.N(N_LAYERS)) u_prio (
    .req (vis),
    .hit (win_hit),
    .idx (win_idx)
  );

  always_comb begin
    win_rgb = vga_in.rgb;
    for (int i = 0; i < N_LAYERS; i++) begin
      if (win_hit && win_idx == IDX_W'(i)) win_rgb = layer_rgb[i];
    end
  end

  // Stage 1 captures the pixel decision; stage 2 applies the blank override.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_hcount <= '0; s1_vcount <= '0;
      s1_hsync  <= 1'b0; s1_vsync <= 1'b0;
      s1_hblnk  <= 1'b0; s1_vblnk <= 1'b0;
      s1_blank  <= 1'b0; s1_rgb   <= '0;
      vga_out.hcount <= '0; vga_out.vcount <= '0;
      vga_out.hsync  <= 1'b0; vga_out.vsync <= 1'b0;
      vga_out.hblnk  <= 1'b0; vga_out.vblnk <= 1'b0;
      vga_out.rgb    <= '0;
    end else begin
      s1_hcount <= vga_in.hcount; s1_vcount <= vga_in.vcount;
      s1_hsync  <= vga_in.hsync;  s1_vsync  <= vga_in.vsync;
      s1_hblnk  <= vga_in.hblnk;  s1_vblnk  <= vga_in.vblnk;
      s1_blank  <= vga_in.hblnk | vga_in.vblnk;
      s1_rgb    <= win_rgb;
      vga_out.hcount <= s1_hcount; vga_out.vcount <= s1_vcount;
      vga_out.hsync  <= s1_hsync;  vga_out.vsync  <= s1_vsync;
      vga_out.hblnk  <= s1_hblnk;  vga_out.vblnk  <= s1_vblnk;
      vga_out.rgb    <= s1_blank ? BLANK_RGB : s1_rgb;
    end
  end

  // WAIT_DROP keeps a held request from committing again every frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      layer_en  <= '1;
      pend_mask <= '0;
      cfg_ack   <= 1'b0;
      vblnk_q   <= 1'b0;
    end else begin
      vblnk_q <= vga_in.vblnk;
      cfg_ack <= 1'b0;
      case (state)
        IDLE:      if (cfg_req) begin pend_mask <= cfg_mask; state <= PENDING; end
        PENDING:   if (vblank_rise) begin layer_en <= pend_mask; state <= COMMIT; end
        COMMIT:    begin cfg_ack <= 1'b1; state <= WAIT_DROP; end
        WAIT_DROP: if (!cfg_req) state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

`ifdef LAYER_ARB_COLLISION_EN
  logic                sticky_hit;
  logic [N_LAYERS-1:0] sticky_mask;
  logic                hit_now;

  assign hit_now = ~(vga_in.hblnk | vga_in.vblnk) & multi_hot(N_LAYERS_MAX'(vis));

  // The frame summary is published at vblank_rise while the sticky set restarts for the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_hit     <= 1'b0;
      sticky_mask    <= '0;
      collision      <= 1'b0;
      collision_mask <= '0;
    end else if (vblank_rise) begin
      collision      <= sticky_hit;
      collision_mask <= sticky_mask;
      sticky_hit     <= hit_now;
      sticky_mask    <= hit_now ? vis : '0;
    end else begin
      sticky_hit <= sticky_hit | hit_now;
      if (hit_now) sticky_mask <= sticky_mask | vis;
    end
  end
`else
  assign collision      = 1'b0;
  assign collision_mask = '0;
`endif
endmodule
